// File: rtl/chunk_assembler.sv
`default_nettype none
// ============================================================================
//  Module   : chunk_assembler
//  Brief    : Collects a row-major pixel stream into CELL_SIZE x (CHUNK_SIZE
//             cells of CELL_SIZE pixels) video chunks, ping-pong buffered,
//             and presents each chunk as one wide word for the transposer.
//  Revision : 1.0 - initial release
// ============================================================================
module chunk_assembler #(
    parameter int CELL_SIZE  = 2,
    parameter int CHUNK_SIZE = 3,
    parameter int PIX_W      = 24
) (
    input  logic                                          clk,
    input  logic                                          resetn,
    input  logic [PIX_W-1:0]                              in_pixel,
    input  logic                                          in_first,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [CELL_SIZE*CHUNK_SIZE*CELL_SIZE*PIX_W-1:0] out_video_chunk,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic [7:0]                                    resync_count
);

    localparam int c_W       = CHUNK_SIZE * CELL_SIZE;   // pixels per image row
    localparam int c_N       = CELL_SIZE * c_W;          // pixels per chunk
    localparam int c_CHUNK_W = c_N * PIX_W;
    localparam int c_COL_W   = (c_W > 1) ? $clog2(c_W) : 1;
    localparam int c_ROW_W   = (CELL_SIZE > 1) ? $clog2(CELL_SIZE) : 1;
    localparam int c_IDX_W   = (c_N > 1) ? $clog2(c_N) : 1;

    // Two chunk banks; input fills r_wr_sel while output presents r_rd_sel
    logic [c_CHUNK_W-1:0] r_bank [2];
    logic [1:0]           r_full;
    logic                 r_wr_sel;
    logic                 r_rd_sel;
    logic [c_COL_W-1:0]   r_col;
    logic [c_ROW_W-1:0]   r_row;
    logic [7:0]           r_resync_count;

    logic                 w_accept;
    logic                 w_drain;
    logic                 w_at_origin;
    logic                 w_resync;
    logic                 w_last_col;
    logic                 w_last_row;
    logic [c_IDX_W-1:0]   w_idx;

    assign in_ready     = resetn & ~r_full[r_wr_sel];
    assign w_accept     = in_valid & in_ready;
    assign out_valid    = r_full[r_rd_sel];
    assign w_drain      = out_valid & out_ready;

    assign w_at_origin  = (r_col == '0) && (r_row == '0);
    // A chunk-start marker in mid-chunk restarts the chunk from this pixel
    assign w_resync     = in_first & ~w_at_origin;
    assign w_last_col   = (r_col == c_COL_W'(c_W - 1));
    assign w_last_row   = (r_row == c_ROW_W'(CELL_SIZE - 1));

    // The chunk word is laid out so that pixel k of the stream lands at k*PIX_W
    assign w_idx        = w_resync ? '0
                                   : c_IDX_W'(int'(r_row) * c_W + int'(r_col));

    assign out_video_chunk = out_valid ? r_bank[r_rd_sel] : '0;
    assign resync_count    = r_resync_count;

    // Pixel storage: a full bank is never written, so its contents stay stable
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_bank[r_wr_sel][int'(w_idx)*PIX_W +: PIX_W] <= in_pixel;
        end
    end

    // Bank flags, pointers, write counters and resync statistics
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_full         <= '0;
            r_wr_sel       <= 1'b0;
            r_rd_sel       <= 1'b0;
            r_col          <= '0;
            r_row          <= '0;
            r_resync_count <= '0;
        end else begin
            // Drain and completion always target different banks, so both apply
            if (w_drain) begin
                r_full[r_rd_sel] <= 1'b0;
                r_rd_sel         <= ~r_rd_sel;
            end
            if (w_accept) begin
                if (w_resync) begin
                    r_col <= c_COL_W'(1);
                    r_row <= '0;
                    if (r_resync_count != 8'hFF) begin
                        r_resync_count <= r_resync_count + 8'd1;
                    end
                end else if (w_last_col) begin
                    r_col <= '0;
                    if (w_last_row) begin
                        r_row            <= '0;
                        r_full[r_wr_sel] <= 1'b1;
                        r_wr_sel         <= ~r_wr_sel;
                    end else begin
                        r_row <= r_row + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/chunk_assembler.md
Name: chunk_assembler

Overview:
- Sits directly upstream of chunk_transposer_wrapper.
- Collects a row-major pixel stream, one pixel per beat, into a complete video chunk: CELL_SIZE image rows, each CHUNK_SIZE cells of CELL_SIZE pixels.
- Presents each completed chunk as one wide word whose layout matches the transposer's video_chunk input.
- Ping-pong buffered, so input streams at full rate while the downstream stage holds a chunk.

Parameters:
- CELL_SIZE, 2, pixels per cell edge; also the number of image rows per chunk.
- CHUNK_SIZE, 3, cells per chunk row.
- PIX_W, 24, pixel width; format is {R[23:16], G[15:8], B[7:0]}.

Ports:
- clk  in  1  sole clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- in_pixel  in  PIX_W  input pixel.
- in_first  in  1  marks the first pixel of a chunk (top-left); qualified by the input handshake.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready.
- out_video_chunk  out  CELL_SIZE*CHUNK_SIZE*CELL_SIZE*PIX_W  assembled chunk.
- out_valid  out  1  chunk available.
- out_ready  in  1  chunk consumed when out_valid & out_ready.
- resync_count  out  8  saturating count of partial chunks discarded.

Behaviour:
- W = CHUNK_SIZE*CELL_SIZE pixels per row; N = CELL_SIZE*W pixels per chunk (12 at defaults).
- Element [r][c][p] (row r, cell c, pixel p within cell) sits at bit offset ((r*CHUNK_SIZE + c)*CELL_SIZE + p)*PIX_W.
- Input pixel k of a chunk maps to r = k / W, c = (k % W) / CELL_SIZE, p = k % CELL_SIZE.
- State:
  - Two banks, B0 and B1, each with a full flag.
  - wr_sel and rd_sel bank pointers.
  - Write counters col (0..W-1) and row (0..CELL_SIZE-1).
- Reset (resetn=0 at a clock edge):
  - Full flags cleared; wr_sel, rd_sel, col, row and resync_count set to 0.
  - out_valid=0; out_video_chunk=0.
  - in_ready is forced to 0 combinationally while resetn is low.
  - A partial chunk in progress is discarded; resync_count is not incremented for it.
- in_ready = resetn & ~full[wr_sel].
- Accept (in_valid & in_ready):
  - Pixel is written at the current (row, col) of bank wr_sel.
  - col increments; at W-1 it wraps to 0 and row increments.
  - On the last pixel (row=CELL_SIZE-1, col=W-1): full[wr_sel] <= 1, wr_sel toggles, counters return to 0.
- Resync: if an accepted pixel has in_first=1 while (row, col) != (0, 0):
  - The partial data is abandoned.
  - The pixel is written as pixel 0 of the same bank; counters become (0, 1).
  - resync_count increments, saturating at 255.
- in_first=1 at (0, 0) is normal. in_first=0 at (0, 0) is accepted without check.
- Output:
  - out_valid = full[rd_sel].
  - out_video_chunk = bank[rd_sel] when out_valid=1, otherwise 0.
  - Data is stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: full[rd_sel] <= 0 and rd_sel toggles.
- Latency: out_valid rises on the clock edge that accepts pixel N-1, i.e. it is visible in the next cycle.
- Completing a chunk into one bank and draining the other bank in the same cycle are both honoured.
- Both banks full: in_ready=0 and the input stalls with no data loss. A drain in cycle t makes in_ready=1 in cycle t+1.
- Throughput: one pixel per cycle sustained when out_ready=1.

Test Plan:
- Reset, then stream 12 pixels 0xA00000+k (k=0..11) with out_ready=1:
  - out_valid=1 for exactly one cycle, one cycle after pixel 11 is accepted.
  - Element [1][2][1] = 0xA0000B; element [0][1][0] = 0xA00002.
  - Round-trip this chunk through chunk_transposer_wrapper and inverse_chunk_transposer_wrapper; the result equals the input.
- out_ready=0, stream 36 pixels continuously:
  - in_ready drops after pixel 23 is accepted (both banks full).
  - out_video_chunk holds chunk 0 unchanged.
  - Raise out_ready: chunks 0 and 1 drain in order, and pixels 24..35 form chunk 2.
- Stream 5 pixels, then a pixel 0xFFFFFF with in_first=1, then 11 more:
  - resync_count=1.
  - Output chunk element [0][0][0] = 0xFFFFFF; the first 5 pixels never appear.
- Drive resetn=0 for one cycle after 7 pixels, then stream 12 fresh pixels:
  - Exactly one chunk is emitted, containing only the fresh pixels.
  - resync_count=0.
- Back-to-back chunks with out_ready toggling every cycle:
  - No pixel is lost or duplicated across 10 chunks (scoreboard).
  - Completion in one bank and drain of the other in the same cycle are handled correctly.
- Force 300 resyncs -> resync_count saturates at 255.
